// File: rtl/sort_floats_seq_scheduler.sv
// Ascending sort of N IEEE-754 floats by scheduling one shared, req/ack float comparator.
// Bubble sort with a shrinking inner loop; Inf/NaN inputs and comparator errors raise err.
package sort_floats_seq_cfg_pkg;
  localparam int FLEN = 64;
  localparam int NE   = 11;
endpackage

module sort_floats_seq_scheduler #(
  parameter int N    = 3,
  parameter int FLEN = sort_floats_seq_cfg_pkg::FLEN,
  parameter int NE   = sort_floats_seq_cfg_pkg::NE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [0:N-1][FLEN-1:0] unsorted,
  output logic                   cmp_req,
  output logic [FLEN-1:0]        cmp_a,
  output logic [FLEN-1:0]        cmp_b,
  input  logic                   cmp_ack,
  input  logic                   cmp_le,
  input  logic                   cmp_err,
  output logic                   valid_out,
  output logic [0:N-1][FLEN-1:0] sorted,
  output logic                   err
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // An all-ones exponent field marks Inf or NaN.
  function automatic logic any_special(input logic [0:N-1][FLEN-1:0] arr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (arr[i][FLEN-2 -: NE] == {NE{1'b1}}) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  state_t                 state_r, state_nxt_s;
  logic [0:N-1][FLEN-1:0] work_r, work_nxt_s;
  logic [0:N-1][FLEN-1:0] sorted_r, sorted_nxt_s;
  logic [CW-1:0]          pass_r, pass_nxt_s;
  logic [CW-1:0]          j_r, j_nxt_s;
  logic [CW-1:0]          j_plus1_s;
  logic [CW-1:0]          last_j_s;
  logic                   err_r, err_nxt_s;
  logic                   ready_r, req_r, valid_r;
  logic                   any_special_s;

  assign any_special_s = any_special(unsorted);
  assign j_plus1_s     = j_r + CW'(1);
  assign last_j_s      = LAST_IDX - pass_r;

  assign ready_out = ready_r;
  assign cmp_req   = req_r;
  assign valid_out = valid_r;
  assign sorted    = sorted_r;
  assign err       = err_r;
  assign cmp_a     = work_r[j_r];
  assign cmp_b     = work_r[j_plus1_s];

  // Next-state, work array and result update.
  always_comb begin
    state_nxt_s  = state_r;
    work_nxt_s   = work_r;
    sorted_nxt_s = sorted_r;
    pass_nxt_s   = pass_r;
    j_nxt_s      = j_r;
    err_nxt_s    = err_r;
    case (state_r)
      IDLE: begin
        if (valid_in && ready_r) begin
          work_nxt_s = unsorted;
          pass_nxt_s = '0;
          j_nxt_s    = '0;
          if (any_special_s) begin
            state_nxt_s  = DONE;
            err_nxt_s    = 1'b1;
            sorted_nxt_s = unsorted;
          end else begin
            state_nxt_s = CMP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CMP: begin
        if (cmp_ack) begin
          if (cmp_err) begin
            // Abandon the remaining compares; report the array as it stands.
            state_nxt_s  = DONE;
            err_nxt_s    = 1'b1;
            sorted_nxt_s = work_r;
          end else begin
            if (!cmp_le) begin
              work_nxt_s[j_r]       = work_r[j_plus1_s];
              work_nxt_s[j_plus1_s] = work_r[j_r];
            end else begin
              work_nxt_s = work_r;
            end
            if (j_r == last_j_s) begin
              if (pass_r == LAST_IDX) begin
                state_nxt_s  = DONE;
                err_nxt_s    = 1'b0;
                sorted_nxt_s = work_nxt_s;
              end else begin
                pass_nxt_s = pass_r + CW'(1);
                j_nxt_s    = '0;
              end
            end else begin
              j_nxt_s = j_plus1_s;
            end
          end
        end else begin
          state_nxt_s = CMP;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      work_r   <= '0;
      sorted_r <= '0;
      pass_r   <= '0;
      j_r      <= '0;
      err_r    <= 1'b0;
      ready_r  <= 1'b1;
      req_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      work_r   <= work_nxt_s;
      sorted_r <= sorted_nxt_s;
      pass_r   <= pass_nxt_s;
      j_r      <= j_nxt_s;
      err_r    <= err_nxt_s;
      ready_r  <= (state_nxt_s == IDLE);
      req_r    <= (state_nxt_s == CMP);
      valid_r  <= (state_nxt_s == DONE);
    end
  end

endmodule
